decrypt_path: RTL



---
 rtl/decrypt_path_pkg.sv | 12 +
 rtl/div_restore_step.sv | 22 ++
 rtl/decrypt_path.sv | 112 +++++++++++
 3 files changed

// File: rtl/decrypt_path_pkg.sv
// decrypt_path_pkg: widths, FSM state codes and step constants shared with the encryption chain.
package decrypt_path_pkg;
  localparam int DATA_W    = 8;
  localparam int KEY_W     = 4;
  localparam int ADDR_W    = 4;
  localparam int DIV_STEPS = DATA_W;
  localparam int ROT_AMT   = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_DIV  = 2'd3;
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one combinational restoring-division step on {rem, quo}.
module div_restore_step
  import decrypt_path_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int KW = KEY_W
) (
  input  logic [KW:0]   rem_i,
  input  logic [DW-1:0] quo_i,
  input  logic [KW-1:0] div_i,
  output logic [KW:0]   rem_o,
  output logic [DW-1:0] quo_o
);
  logic [KW+1:0] sh, dif;
  logic ge;
  assign sh    = {rem_i, quo_i[DW-1]};
  assign dif   = sh - {2'b00, div_i};
  // a set top bit means sh already exceeds any KW-bit divisor
  assign ge    = sh[KW+1] | ~dif[KW+1];
  assign rem_o = ge ? dif[KW:0] : sh[KW:0];
  assign quo_o = {quo_i[DW-2:0], ge};
endmodule

// File: rtl/decrypt_path.sv
// decrypt_path: reads a ciphertext word, divides it by the key and un-rotates the quotient.
module decrypt_path
  import decrypt_path_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int KW = KEY_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] key,
  input  logic [AW-1:0] addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic [KW-1:0] num,
  output logic          err
);
  localparam int CW = $clog2(DW + 1);
  logic [1:0]    state_q, state_d;
  logic [KW-1:0] key_q, key_d, num_q, num_d;
  logic [KW:0]   rem_q, rem_d, rem_nx;
  logic [DW-1:0] quo_q, quo_d, quo_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d, bad;
  div_restore_step #(.DW(DW), .KW(KW)) u_step (
    .rem_i(rem_q), .quo_i(quo_q), .div_i(key_q), .rem_o(rem_nx), .quo_o(quo_nx)
  );
  // leftover remainder or a quotient wider than the plaintext cannot be real ciphertext
  assign bad = (|rem_nx) | (|quo_nx[DW-1:KW]);
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    num_d     = num_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        busy_d    = start;
        key_d     = start ? key : key_q;
        rd_addr_d = start ? addr : rd_addr_q;
        rd_en_d   = start;
        state_d   = start ? ST_READ : ST_IDLE;
      end
      ST_READ: state_d = ST_CAPT;
      ST_CAPT: begin
        done_d  = key_q == '0;
        err_d   = key_q == '0 ? 1'b1 : err_q;
        num_d   = key_q == '0 ? '0 : num_q;
        rem_d   = '0;
        quo_d   = rd_data;
        cnt_d   = CW'(DW);
        state_d = key_q == '0 ? ST_IDLE : ST_DIV;
      end
      ST_DIV: begin
        rem_d  = rem_nx;
        quo_d  = quo_nx;
        cnt_d  = cnt_q - CW'(1);
        done_d = cnt_q == CW'(1);
        if (cnt_q == CW'(1)) begin
          err_d   = bad;
          num_d   = bad ? '0 : {quo_nx[ROT_AMT-1:0], quo_nx[KW-1:ROT_AMT]};
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      num_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      num_q     <= num_d;
      err_q     <= err_d;
    end
  end
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign num     = num_q;
  assign err     = err_q;
endmodule
